// File: rtl/id_exe_pkg.sv
// Shared definitions for the ID/EXE pipeline register: control-bit layout,
// buffer state encoding and the default-width stage bundle.
package id_exe_pkg;

  localparam int CTRLW = 5;
  localparam int WE_B  = 4;
  localparam int BR_B  = 3;
  localparam int MW_B  = 2;
  localparam int MR_B  = 1;
  localparam int M2R_B = 0;

  localparam int DW_DEF  = 16;
  localparam int AW_DEF  = 4;
  localparam int OPW_DEF = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKIDF = 2'd2
  } pipe_state_e;

  // Default-width view of everything that travels from ID to EXE.
  typedef struct packed {
    logic [DW_DEF-1:0]  aluin1;
    logic [DW_DEF-1:0]  aluin2;
    logic [DW_DEF-1:0]  rdata2;
    logic [DW_DEF-1:0]  imm;
    logic [AW_DEF-1:0]  waddr;
    logic [CTRLW-1:0]   ctrl;
    logic [OPW_DEF-1:0] aluop;
  } id_exe_bus_t;

  function automatic logic [CTRLW-1:0] ctrl_bubble(input logic valid,
                                                   input logic [CTRLW-1:0] ctrl);
    return valid ? ctrl : '0;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice with flush. SKID=1 adds a second entry so
// in_ready_o is registered; SKID=0 is a single entry with pass-through ready.
module pipe_skid_buf
  import id_exe_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output pipe_state_e  state_o
);

  pipe_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         pop;

  assign out_valid_o = (state_q != EMPTY);
  assign out_data_o  = main_q;
  assign state_o     = state_q;

  // Single-entry mode may only refill when the head leaves this same cycle.
  assign in_ready_o = SKID ? (state_q != SKIDF)
                           : ((state_q == EMPTY) || out_ready_i);

  assign accept = in_valid_i && in_ready_o;
  assign pop    = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = FULL;
            main_d  = in_data_i;
          end
        end
        FULL: begin
          if (accept && !pop) begin
            state_d = SKIDF;
            skid_d  = in_data_i;
          end else if (accept && pop) begin
            main_d = in_data_i;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        SKIDF: begin
          // The older entry sits in main, so the skid entry moves up behind it.
          if (pop) begin
            state_d = FULL;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID/EXE pipeline register with valid/ready flow control, flush to bubble and
// a saturating count of cycles where EXE back-pressures a valid head.
module id_exe_pipe_reg
  import id_exe_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int OPW  = 3,
  parameter bit SKID = 1'b1,
  parameter int CW   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    aluin1_in,
  input  logic [DW-1:0]    aluin2_in,
  input  logic [DW-1:0]    rdata2_in,
  input  logic [DW-1:0]    imm_in,
  input  logic [AW-1:0]    waddr_in,
  input  logic [CTRLW-1:0] ctrl_in,
  input  logic [OPW-1:0]   aluop_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    aluin1_out,
  output logic [DW-1:0]    aluin2_out,
  output logic [DW-1:0]    rdata2_out,
  output logic [DW-1:0]    imm_out,
  output logic [AW-1:0]    waddr_out,
  output logic [CTRLW-1:0] ctrl_out,
  output logic [OPW-1:0]   aluop_out,
  output logic [CW-1:0]    stall_cnt
);

  typedef struct packed {
    logic [DW-1:0]    aluin1;
    logic [DW-1:0]    aluin2;
    logic [DW-1:0]    rdata2;
    logic [DW-1:0]    imm;
    logic [AW-1:0]    waddr;
    logic [CTRLW-1:0] ctrl;
    logic [OPW-1:0]   aluop;
  } bus_t;

  localparam int BW = $bits(bus_t);

  bus_t        in_bus;
  bus_t        out_bus;
  pipe_state_e buf_state;
  logic        head_valid;
  logic        stalled;
  logic [CW-1:0] stall_q, stall_d;

  assign in_bus = '{aluin1: aluin1_in, aluin2: aluin2_in, rdata2: rdata2_in,
                    imm: imm_in, waddr: waddr_in, ctrl: ctrl_in, aluop: aluop_in};

  pipe_skid_buf #(
    .W    (BW),
    .SKID (SKID)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_bus),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_bus),
    .state_o     (buf_state)
  );

  assign head_valid = (buf_state != EMPTY);

  assign aluin1_out = out_bus.aluin1;
  assign aluin2_out = out_bus.aluin2;
  assign rdata2_out = out_bus.rdata2;
  assign imm_out    = out_bus.imm;
  assign waddr_out  = out_bus.waddr;
  // A bubble must never look like a write, branch or memory access downstream.
  assign ctrl_out   = ctrl_bubble(head_valid, out_bus.ctrl);
  assign aluop_out  = head_valid ? out_bus.aluop : '0;

  assign stalled = head_valid && !out_ready;

  always_comb begin
    stall_d = stall_q;
    if (!flush && stalled && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: a SKID=1 instance, a SKID=0 instance
// and a CW=3 instance for counter saturation.
module tb_id_exe_pipe_reg;
  import id_exe_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int OPW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_z = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  // Shared payload inputs
  logic [DW-1:0]    aluin2_in = '0, rdata2_in = '0, imm_in = '0;
  logic [AW-1:0]    waddr_in = '0;
  logic [CTRLW-1:0] ctrl_in = '0;
  logic [OPW-1:0]   aluop_in = '0;

  // Main instance (SKID=1)
  logic             in_valid = 1'b0, out_ready = 1'b1, in_ready, out_valid;
  logic [DW-1:0]    aluin1_in = '0;
  logic [DW-1:0]    aluin1_out, aluin2_out, rdata2_out, imm_out;
  logic [AW-1:0]    waddr_out;
  logic [CTRLW-1:0] ctrl_out;
  logic [OPW-1:0]   aluop_out;
  logic [15:0]      stall_cnt;

  // SKID=0 instance
  logic             s0_in_valid = 1'b0, s0_out_ready = 1'b1, s0_in_ready, s0_out_valid;
  logic [DW-1:0]    s0_aluin1 = '0;
  logic [DW-1:0]    s0_aluin1_out, s0_aluin2_out, s0_rdata2_out, s0_imm_out;
  logic [AW-1:0]    s0_waddr_out;
  logic [CTRLW-1:0] s0_ctrl_out;
  logic [OPW-1:0]   s0_aluop_out;
  logic [15:0]      s0_stall_cnt;

  // CW=3 instance
  logic             sat_in_valid = 1'b0, sat_out_ready = 1'b1, sat_in_ready, sat_out_valid;
  logic [DW-1:0]    sat_aluin1 = '0;
  logic [DW-1:0]    sat_aluin1_out, sat_aluin2_out, sat_rdata2_out, sat_imm_out;
  logic [AW-1:0]    sat_waddr_out;
  logic [CTRLW-1:0] sat_ctrl_out;
  logic [OPW-1:0]   sat_aluop_out;
  logic [2:0]       sat_stall_cnt;

  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  id_exe_pipe_reg #(.DW(DW), .AW(AW), .OPW(OPW), .SKID(1'b1), .CW(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluin1_in(aluin1_in), .aluin2_in(aluin2_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .waddr_in(waddr_in), .ctrl_in(ctrl_in), .aluop_in(aluop_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluin1_out(aluin1_out), .aluin2_out(aluin2_out), .rdata2_out(rdata2_out), .imm_out(imm_out),
    .waddr_out(waddr_out), .ctrl_out(ctrl_out), .aluop_out(aluop_out), .stall_cnt(stall_cnt)
  );

  id_exe_pipe_reg #(.DW(DW), .AW(AW), .OPW(OPW), .SKID(1'b0), .CW(16)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush_z), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .aluin1_in(s0_aluin1), .aluin2_in(aluin2_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .waddr_in(waddr_in), .ctrl_in(ctrl_in), .aluop_in(aluop_in),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .aluin1_out(s0_aluin1_out), .aluin2_out(s0_aluin2_out), .rdata2_out(s0_rdata2_out),
    .imm_out(s0_imm_out), .waddr_out(s0_waddr_out), .ctrl_out(s0_ctrl_out),
    .aluop_out(s0_aluop_out), .stall_cnt(s0_stall_cnt)
  );

  id_exe_pipe_reg #(.DW(DW), .AW(AW), .OPW(OPW), .SKID(1'b1), .CW(3)) u_sat (
    .clk(clk), .rst(rst), .flush(flush_z), .in_valid(sat_in_valid), .in_ready(sat_in_ready),
    .aluin1_in(sat_aluin1), .aluin2_in(aluin2_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .waddr_in(waddr_in), .ctrl_in(ctrl_in), .aluop_in(aluop_in),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready),
    .aluin1_out(sat_aluin1_out), .aluin2_out(sat_aluin2_out), .rdata2_out(sat_rdata2_out),
    .imm_out(sat_imm_out), .waddr_out(sat_waddr_out), .ctrl_out(sat_ctrl_out),
    .aluop_out(sat_aluop_out), .stall_cnt(sat_stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; aluin1_in = 16'h0055; ctrl_in = 5'h1F; aluop_in = 3'h7;
    s0_in_valid = 1'b1; sat_in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (ctrl_out !== 5'h00) begin n_err++; $display("FAIL rst_ctrl_out got=%0h exp=0", ctrl_out); end
    n_cmp++; if (aluop_out !== 3'h0) begin n_err++; $display("FAIL rst_aluop_out got=%0h exp=0", aluop_out); end
    n_cmp++; if (aluin1_out !== 16'h0000) begin n_err++; $display("FAIL rst_aluin1_out got=%0h exp=0", aluin1_out); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    n_cmp++; if (s0_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_s0_out_valid got=%0h exp=0", s0_out_valid); end
    rst = 1'b0; in_valid = 1'b0; s0_in_valid = 1'b0; sat_in_valid = 1'b0; out_ready = 1'b1;
    ctrl_in = '0; aluop_in = '0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%0h exp=1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_out_valid got=%0h exp=0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; aluin1_in = 16'(i); aluin2_in = 16'(i * 16); imm_in = 16'h0100 + 16'(i);
      waddr_in = 4'(i); ctrl_in = 5'(i); aluop_in = 3'(i);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got=%0h exp=1", i, out_valid); end
      n_cmp++; if (aluin1_out !== 16'(i)) begin n_err++; $display("FAIL stream_aluin1[%0d] got=%0h exp=%0h", i, aluin1_out, i); end
      n_cmp++; if (aluin2_out !== 16'(i * 16)) begin n_err++; $display("FAIL stream_aluin2[%0d] got=%0h exp=%0h", i, aluin2_out, i * 16); end
      n_cmp++; if (imm_out !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL stream_imm[%0d] got=%0h exp=%0h", i, imm_out, 16'h0100 + i); end
      n_cmp++; if (waddr_out !== 4'(i)) begin n_err++; $display("FAIL stream_waddr[%0d] got=%0h exp=%0h", i, waddr_out, i); end
      n_cmp++; if (ctrl_out !== 5'(i)) begin n_err++; $display("FAIL stream_ctrl[%0d] got=%0h exp=%0h", i, ctrl_out, i); end
      n_cmp++; if (aluop_out !== 3'(i)) begin n_err++; $display("FAIL stream_aluop[%0d] got=%0h exp=%0h", i, aluop_out, i); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got=%0h exp=1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (ctrl_out !== 5'h00) begin n_err++; $display("FAIL stream_drain_ctrl got=%0h exp=0", ctrl_out); end
    n_cmp++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL stream_stall got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; aluin1_in = 16'h00AA; ctrl_in = 5'h11; aluop_in = 3'h1;
    tick();
    n_cmp++; if (aluin1_out !== 16'h00AA) begin n_err++; $display("FAIL bp_head_a got=%0h exp=aa", aluin1_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got=%0h exp=1", in_ready); end
    aluin1_in = 16'h00BB; ctrl_in = 5'h12; aluop_in = 3'h2;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got=%0h exp=0", in_ready); end
    n_cmp++; if (u_dut.buf_state !== SKIDF) begin n_err++; $display("FAIL bp_state got=%0d exp=%0d", u_dut.buf_state, SKIDF); end
    n_cmp++; if (aluin1_out !== 16'h00AA || ctrl_out !== 5'h11) begin n_err++; $display("FAIL bp_hold1 got=%0h/%0h exp=aa/11", aluin1_out, ctrl_out); end
    n_cmp++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL bp_stall1 got=%0d exp=1", stall_cnt); end
    aluin1_in = 16'h00DD;
    tick();
    n_cmp++; if (aluin1_out !== 16'h00AA || aluop_out !== 3'h1) begin n_err++; $display("FAIL bp_hold2 got=%0h/%0h exp=aa/1", aluin1_out, aluop_out); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL bp_stall2 got=%0d exp=2", stall_cnt); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || aluin1_out !== 16'h00BB || ctrl_out !== 5'h12) begin n_err++; $display("FAIL bp_head_b got=%0h/%0h/%0h exp=1/bb/12", out_valid, aluin1_out, ctrl_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready3 got=%0h exp=1", in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%0h exp=0", out_valid); end
    n_cmp++; if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL bp_stall3 got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; aluin1_in = 16'h0011; ctrl_in = 5'h1F; aluop_in = 3'h5;
    tick();
    aluin1_in = 16'h0022;
    tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fl_pre_ready got=%0h exp=0", in_ready); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL fl_pre_stall got=%0d exp=3", stall_cnt); end
    flush = 1'b1; aluin1_in = 16'h00CC; aluop_in = 3'h7;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got=%0h exp=0", out_valid); end
    n_cmp++; if (ctrl_out !== 5'h00) begin n_err++; $display("FAIL fl_ctrl got=%0h exp=0", ctrl_out); end
    n_cmp++; if (aluop_out !== 3'h0) begin n_err++; $display("FAIL fl_aluop got=%0h exp=0", aluop_out); end
    n_cmp++; if (stall_cnt !== 16'd3) begin n_err++; $display("FAIL fl_stall got=%0d exp=3", stall_cnt); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready got=%0h exp=1", in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ctrl_in = '0; aluop_in = '0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_no_c got=%0h exp=0", out_valid); end
  endtask

  task automatic test_skid0();
    bit        ordy[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit        ivld[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit        eirdy[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [DW-1:0] d;
    bit        acc;
    bit        popd;
    d = 16'h0031;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      s0_out_ready = ordy[i]; s0_in_valid = ivld[i]; s0_aluin1 = d;
      #1;
      n_cmp++; if (s0_in_ready !== eirdy[i]) begin n_err++; $display("FAIL s0_in_ready[%0d] got=%0h exp=%0h", i, s0_in_ready, eirdy[i]); end
      acc  = ivld[i] && eirdy[i];
      popd = (exp_q.size() > 0) && ordy[i];
      tick();
      if (popd) void'(exp_q.pop_front());
      if (acc) begin exp_q.push_back(d); d = d + 16'd1; end
      n_cmp++; if (s0_out_valid !== (exp_q.size() > 0)) begin n_err++; $display("FAIL s0_valid[%0d] got=%0h exp=%0h", i, s0_out_valid, exp_q.size() > 0); end
      if (exp_q.size() > 0) begin
        n_cmp++; if (s0_aluin1_out !== exp_q[0]) begin n_err++; $display("FAIL s0_data[%0d] got=%0h exp=%0h", i, s0_aluin1_out, exp_q[0]); end
      end
    end
    s0_in_valid = 1'b0; s0_out_ready = 1'b1;
    n_cmp++; if (d !== 16'h0034) begin n_err++; $display("FAIL s0_accepted got=%0h exp=34", d); end
    n_cmp++; if (s0_stall_cnt !== 16'd1) begin n_err++; $display("FAIL s0_stall got=%0d exp=1", s0_stall_cnt); end
  endtask

  task automatic test_saturation();
    sat_out_ready = 1'b0; sat_in_valid = 1'b1; sat_aluin1 = 16'h0077;
    tick();
    n_cmp++; if (sat_out_valid !== 1'b1 || sat_stall_cnt !== 3'd0) begin n_err++; $display("FAIL sat_load got=%0h/%0d exp=1/0", sat_out_valid, sat_stall_cnt); end
    sat_in_valid = 1'b0;
    repeat (6) tick();
    n_cmp++; if (sat_stall_cnt !== 3'd6) begin n_err++; $display("FAIL sat_six got=%0d exp=6", sat_stall_cnt); end
    repeat (4) tick();
    n_cmp++; if (sat_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_max got=%0d exp=7", sat_stall_cnt); end
    n_cmp++; if (sat_aluin1_out !== 16'h0077) begin n_err++; $display("FAIL sat_hold got=%0h exp=77", sat_aluin1_out); end
    sat_out_ready = 1'b1;
    tick();
    n_cmp++; if (sat_out_valid !== 1'b0 || sat_stall_cnt !== 3'd7) begin n_err++; $display("FAIL sat_drain got=%0h/%0d exp=0/7", sat_out_valid, sat_stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
